spi_frame_master: RTL and testbench

SPI_FRAME_MASTER -- requirements
Module: spi_frame_master

---
 rtl/spi_frame_master.sv | 137 +++++++++++++
 tb/tb_spi_frame_master.sv | 206 ++++++++++++++++++++
 2 files changed

// File: rtl/spi_frame_master.sv
// spi_frame_master: serial frame master sending a 16-bit command frame
// (rw, ext_addr, reserved, reg_addr, data) on mosi with an active-high cs.
// On reads it samples the slave reply on miso with a configurable delay.
// Frames are separated by a guaranteed cs-low gap.
//
// state | meaning
// IDLE  | waiting for start, cs low
// SHIFT | frame cycles 0..15, mosi carries the frame LSB-first
// TAIL  | MISO_DLY-1 extra cs-high cycles so late read samples can land
// GAP   | cs low, counting GAP_CYC cycles before the next frame
module spi_frame_master #(
  parameter int unsigned GAP_CYC  = 2,
  parameter int unsigned MISO_DLY = 1
) (
  input  logic       sclk,
  input  logic       rst,
  input  logic       start,
  input  logic       rw,
  input  logic [2:0] ext_addr,
  input  logic [2:0] reg_addr,
  input  logic [7:0] wdata,
  output logic       cs,
  output logic       mosi,
  input  logic       miso,
  input  logic       miso_oe,
  output logic       busy,
  output logic       done,
  output logic [7:0] rdata,
  output logic       rd_err
);

  typedef enum logic [1:0] {IDLE, SHIFT, TAIL, GAP} state_t;

  // cyc value of the cycle that ends on the first / last sample edge
  localparam logic [4:0] SAMP_C   = 5'(7 + MISO_DLY);
  localparam logic [4:0] LAST_C   = 5'(14 + MISO_DLY);
  localparam logic [3:0] GAP_INIT = 4'(GAP_CYC - 1);

  state_t      state;
  logic [4:0]  cyc;
  logic [3:0]  gap_cnt;
  logic [14:0] tx_sr;
  logic [6:0]  rx_sr;
  logic        rx_err;
  logic        rw_q;
  logic [15:0] frame;
  logic [7:0]  rx_next;

  // Assemble the outgoing frame from the live inputs; used only on the accept edge.
  always_comb begin
    frame      = '0;
    frame[0]   = rw;
    frame[3:1] = ext_addr;
    frame[4]   = 1'b0;
    frame[7:5] = reg_addr;
    for (int i = 0; i < 8; i++) begin
      frame[8+i] = rw & wdata[7-i];
    end
  end

  assign rx_next = {rx_sr, miso};

  // Frame sequencer: accept, shift, tail, gap, with all outputs registered.
  // busy drops for the final gap cycle so a waiting start lands on the edge
  // that ends the gap, giving exactly GAP_CYC cs-low cycles between frames.
  always_ff @(posedge sclk or negedge rst) begin
    if (!rst) begin
      state   <= IDLE;
      cyc     <= '0;
      gap_cnt <= '0;
      tx_sr   <= '0;
      rx_sr   <= '0;
      rx_err  <= 1'b0;
      rw_q    <= 1'b0;
      cs      <= 1'b0;
      mosi    <= 1'b0;
      busy    <= 1'b0;
      done    <= 1'b0;
      rdata   <= '0;
      rd_err  <= 1'b0;
    end else begin
      done <= 1'b0;
      if (start && !busy) begin
        state  <= SHIFT;
        busy   <= 1'b1;
        cs     <= 1'b1;
        mosi   <= frame[0];
        tx_sr  <= frame[15:1];
        rw_q   <= rw;
        cyc    <= '0;
        rx_err <= 1'b0;
      end else begin
        case (state)
          SHIFT, TAIL: begin
            if (!rw_q && cyc >= SAMP_C) begin
              rx_sr  <= rx_next[6:0];
              rx_err <= rx_err | ~miso_oe;
            end
            if (cyc == LAST_C) begin
              state   <= GAP;
              cs      <= 1'b0;
              mosi    <= 1'b0;
              done    <= 1'b1;
              busy    <= (GAP_CYC > 1);
              gap_cnt <= GAP_INIT;
              if (!rw_q) begin
                rdata  <= rx_next;
                rd_err <= rx_err | ~miso_oe;
              end else begin
                rd_err <= 1'b0;
              end
            end else begin
              cyc <= cyc + 5'd1;
              if (cyc == 5'd15) begin
                state <= TAIL;
                mosi  <= 1'b0;
              end else begin
                mosi  <= tx_sr[0];
                tx_sr <= {1'b0, tx_sr[14:1]};
              end
            end
          end
          GAP: begin
            if (gap_cnt == 4'd0) begin
              state <= IDLE;
            end else begin
              gap_cnt <= gap_cnt - 4'd1;
              if (gap_cnt == 4'd1) busy <= 1'b0;
            end
          end
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_spi_frame_master.sv
// Directed bench for spi_frame_master: one default instance (GAP_CYC=2,
// MISO_DLY=1) and one with GAP_CYC=3, MISO_DLY=3 sharing the frame fields.
module tb_spi_frame_master;

  logic       sclk = 1'b0;
  logic       rst;
  logic       start1, start3;
  logic       rw;
  logic [2:0] ext_addr, reg_addr;
  logic [7:0] wdata;
  logic       miso, miso_oe;
  logic       cs1, mosi1, busy1, done1, rd_err1;
  logic [7:0] rdata1;
  logic       cs3, mosi3, busy3, done3, rd_err3;
  logic [7:0] rdata3;
  logic       sel;
  logic       cs_s, mosi_s, busy_s, done_s;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 sclk = ~sclk;

  spi_frame_master #(.GAP_CYC(2), .MISO_DLY(1)) dut1 (
    .sclk(sclk), .rst(rst), .start(start1), .rw(rw), .ext_addr(ext_addr),
    .reg_addr(reg_addr), .wdata(wdata), .cs(cs1), .mosi(mosi1), .miso(miso),
    .miso_oe(miso_oe), .busy(busy1), .done(done1), .rdata(rdata1), .rd_err(rd_err1)
  );

  spi_frame_master #(.GAP_CYC(3), .MISO_DLY(3)) dut3 (
    .sclk(sclk), .rst(rst), .start(start3), .rw(rw), .ext_addr(ext_addr),
    .reg_addr(reg_addr), .wdata(wdata), .cs(cs3), .mosi(mosi3), .miso(miso),
    .miso_oe(miso_oe), .busy(busy3), .done(done3), .rdata(rdata3), .rd_err(rd_err3)
  );

  assign cs_s   = sel ? cs3   : cs1;
  assign mosi_s = sel ? mosi3 : mosi1;
  assign busy_s = sel ? busy3 : busy1;
  assign done_s = sel ? done3 : done1;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge sclk);
    #1;
  endtask

  // One complete frame on the selected instance with a slave model that
  // presents sbyte MSB-first so bit (7-j) is on miso just before edge E_(8+j+d).
  task automatic run_frame(input string tag, input bit use3, input logic rw_i,
                           input logic [2:0] ea, input logic [2:0] ra, input logic [7:0] wd,
                           input logic [7:0] sbyte, input logic [7:0] oe_mask,
                           input logic [15:0] exp_mosi, input bit glitch);
    int d, j, cs_cnt, done_cnt, tail_bad;
    logic [15:0] got;
    d = use3 ? 3 : 1;
    sel = use3;
    rw = rw_i; ext_addr = ea; reg_addr = ra; wdata = wd;
    miso = 1'b1; miso_oe = 1'b0;
    if (use3) start3 = 1'b1; else start1 = 1'b1;
    tick();
    start1 = 1'b0; start3 = 1'b0;
    check_val({tag, "_busy_acc"}, busy_s, 1);
    got = '0; cs_cnt = 0; done_cnt = 0; tail_bad = 0;
    for (int n = 0; n < 15 + d; n++) begin
      if (n < 16) got[n] = mosi_s;
      else if (mosi_s !== 1'b0) tail_bad++;
      if (cs_s === 1'b1) cs_cnt++;
      if (done_s !== 1'b0) done_cnt++;
      j = n + 1 - 8 - d;
      if (j >= 0 && j <= 7) begin
        miso = sbyte[7-j]; miso_oe = oe_mask[7-j];
      end else begin
        miso = 1'b1; miso_oe = 1'b0;
      end
      if (glitch && n == 5) begin
        if (use3) start3 = 1'b1; else start1 = 1'b1;
        rw = ~rw_i; wdata = ~wd; ext_addr = ~ea;
      end
      if (glitch && n == 6) begin
        start1 = 1'b0; start3 = 1'b0;
      end
      tick();
    end
    miso = 1'b1; miso_oe = 1'b0;
    check_val({tag, "_mosi"}, got, exp_mosi);
    check_val({tag, "_cs_len"}, cs_cnt, 15 + d);
    check_val({tag, "_tail_mosi"}, tail_bad, 0);
    check_val({tag, "_early_done"}, done_cnt, 0);
    check_val({tag, "_cs_fall"}, cs_s, 0);
    check_val({tag, "_mosi_fall"}, mosi_s, 0);
    check_val({tag, "_done"}, done_s, 1);
    check_val({tag, "_busy_gap"}, busy_s, 1);
    tick();
    check_val({tag, "_done_1cyc"}, done_s, 0);
    check_val({tag, "_busy_end"}, busy_s, use3 ? 1 : 0);
  endtask

  initial begin
    int errs, dn, gap_len;
    bit rose2, exp_cs;
    rst = 1'b1; start1 = 1'b0; start3 = 1'b0; sel = 1'b0;
    rw = 1'b0; ext_addr = '0; reg_addr = '0; wdata = '0;
    miso = 1'b1; miso_oe = 1'b0;
    #1 rst = 1'b0;
    #1;
    check_val("rst_cs", cs1, 0);
    check_val("rst_mosi", mosi1, 0);
    check_val("rst_busy", busy1, 0);
    check_val("rst_done", done1, 0);
    check_val("rst_rdata", rdata1, 8'h00);
    check_val("rst_rd_err", rd_err1, 0);
    repeat (2) tick();
    rst = 1'b1;

    // write 0xAD to ext 7 / reg 7
    run_frame("wr_ad", 0, 1'b1, 3'd7, 3'd7, 8'hAD, 8'h00, 8'h00, 16'hB5EF, 0);
    check_val("wr_ad_rdata", rdata1, 8'h00);
    check_val("wr_ad_rd_err", rd_err1, 0);

    // clean read of 0x5A
    run_frame("rd_5a", 0, 1'b0, 3'd3, 3'd5, 8'hFF, 8'h5A, 8'hFF, 16'h00A6, 0);
    check_val("rd_5a_rdata", rdata1, 8'h5A);
    check_val("rd_5a_rd_err", rd_err1, 0);

    // slave never enables its output
    run_frame("rd_noe", 0, 1'b0, 3'd3, 3'd5, 8'h00, 8'h3C, 8'h00, 16'h00A6, 0);
    check_val("rd_noe_rdata", rdata1, 8'h3C);
    check_val("rd_noe_rd_err", rd_err1, 1);

    // output-enable missing only at the final sample edge
    run_frame("rd_lastoe", 0, 1'b0, 3'd3, 3'd5, 8'h00, 8'h96, 8'hFE, 16'h00A6, 0);
    check_val("rd_lastoe_rdata", rdata1, 8'h96);
    check_val("rd_lastoe_rd_err", rd_err1, 1);

    // write with a mid-frame start and field changes that must be ignored
    run_frame("wr_glitch", 0, 1'b1, 3'd1, 3'd2, 8'h81, 8'h00, 8'h00, 16'h8143, 1);
    check_val("wr_glitch_rdata", rdata1, 8'h96);
    check_val("wr_glitch_rd_err", rd_err1, 0);
    errs = 0;
    for (int k = 0; k < 8; k++) begin
      tick();
      if (cs1 !== 1'b0) errs++;
    end
    check_val("glitch_not_queued", errs, 0);

    // start held high: two back-to-back writes
    sel = 1'b0; rw = 1'b1; ext_addr = 3'd7; reg_addr = 3'd7; wdata = 8'hAD;
    start1 = 1'b1;
    errs = 0; dn = 0; gap_len = 0; rose2 = 1'b0;
    for (int k = 0; k < 40; k++) begin
      tick();
      exp_cs = (k < 16) || (k >= 18 && k < 34);
      if (cs1 !== exp_cs) errs++;
      if (done1 === 1'b1) dn++;
      if (k >= 16 && !rose2) begin
        if (cs1 === 1'b0) gap_len++;
        else rose2 = 1'b1;
      end
      if (k == 20) start1 = 1'b0;
    end
    check_val("b2b_cs_pattern", errs, 0);
    check_val("b2b_gap_len", gap_len, 2);
    check_val("b2b_done_count", dn, 2);

    // reset during frame cycle 9 of a write
    sel = 1'b0; rw = 1'b1; ext_addr = 3'd0; reg_addr = 3'd0; wdata = 8'h7E;
    start1 = 1'b1;
    tick();
    start1 = 1'b0;
    repeat (9) tick();
    check_val("abort_pre_cs", cs1, 1);
    check_val("abort_pre_mosi", mosi1, 1);
    #2 rst = 1'b0;
    #1;
    check_val("abort_cs", cs1, 0);
    check_val("abort_mosi", mosi1, 0);
    check_val("abort_busy", busy1, 0);
    dn = 0;
    repeat (3) begin
      tick();
      if (done1 !== 1'b0) dn++;
    end
    check_val("abort_no_done", dn, 0);
    check_val("abort_rdata", rdata1, 8'h00);
    rst = 1'b1;
    run_frame("post_rst_rd", 0, 1'b0, 3'd3, 3'd5, 8'h00, 8'hC3, 8'hFF, 16'h00A6, 0);
    check_val("post_rst_rdata", rdata1, 8'hC3);
    check_val("post_rst_rd_err", rd_err1, 0);

    // late-sampling instance
    run_frame("d3_rd", 1, 1'b0, 3'd2, 3'd1, 8'h00, 8'hB4, 8'hFF, 16'h0024, 0);
    check_val("d3_rdata", rdata3, 8'hB4);
    check_val("d3_rd_err", rd_err3, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
